// File: rtl/read_guard.sv
// read_guard
//   Watches the AXI read path (AR/R) between a manager and a subordinate.
//   Outstanding reads are tracked per ID in a small table.  Each entry has a
//   count of reads in flight and a budget counter.  The guard escalates to a
//   reset request plus an irq pulse in two cases:
//     - an entry's budget expires before its R-last arrives;
//     - an R-last arrives for an ID that is not tracked.
//   The reset request is held until software acknowledges it.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   rd_en_i           guard enable; AR handshakes are ignored while low
//   budget_i          prescaled ticks allowed per read
//   ar_valid_i/ar_ready_i/ar_id_i          AR channel observation
//   r_valid_i/r_ready_i/r_id_i/r_last_i    R channel observation
//   reset_clear_i     software acknowledge; releases the reset request
//   ar_block_o        upstream must hold off AR (no slot, or not idle)
//   reset_req_o       level reset request to the subordinate
//   irq_o             one-cycle pulse on entry to the reset request
//   err_spur_o        sticky: R-last seen with an untracked ID
//   err_ovf_o         sticky: AR accepted while ar_block_o was high
module read_guard #(
    parameter int IdWidth      = 4,
    parameter int MaxUniqIds   = 4,
    parameter int MaxRdTxns    = 8,
    parameter int CntWidth     = 16,
    parameter int PrescalerDiv = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rd_en_i,
    input  logic [CntWidth-1:0] budget_i,
    input  logic                ar_valid_i,
    input  logic                ar_ready_i,
    input  logic [IdWidth-1:0]  ar_id_i,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic [IdWidth-1:0]  r_id_i,
    input  logic                r_last_i,
    input  logic                reset_clear_i,
    output logic                ar_block_o,
    output logic                reset_req_o,
    output logic                irq_o,
    output logic                err_spur_o,
    output logic                err_ovf_o
);

    localparam int TxnW = $clog2(MaxRdTxns + 1);
    localparam int IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
    localparam int PreW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RESET_REQ = 2'd1;
    localparam logic [1:0] CLEAR     = 2'd2;

    logic [1:0]            state;
    logic [MaxUniqIds-1:0] ent_valid;
    logic [IdWidth-1:0]    ent_id     [MaxUniqIds];
    logic [TxnW-1:0]       ent_cnt    [MaxUniqIds];
    logic [CntWidth-1:0]   ent_budget [MaxUniqIds];
    logic [PreW-1:0]       presc;
    logic                  fault;
    logic                  irq;
    logic                  err_spur;
    logic                  err_ovf;

    logic                  idle;
    logic                  tick;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  ar_hit;
    logic                  r_hit;
    logic                  free_found;
    logic                  no_slot;
    logic                  ar_accept;
    logic                  timeout;
    logic                  fault_now;
    logic [IdxW-1:0]       ar_idx;
    logic [IdxW-1:0]       r_idx;
    logic [IdxW-1:0]       free_idx;
    logic [MaxUniqIds-1:0] ar_sel;
    logic [MaxUniqIds-1:0] alloc_sel;
    logic [MaxUniqIds-1:0] done_sel;
    logic [MaxUniqIds-1:0] expired;

    assign idle  = (state == IDLE);
    assign tick  = (presc == PreW'(PrescalerDiv - 1));
    assign ar_hs = ar_valid_i & ar_ready_i & rd_en_i & idle;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i & idle;

    // Table lookups use registered state only.  The first match wins for
    // hits, and the lowest-index free entry is chosen for allocation.  As a
    // result, a slot freed this cycle is not visible to an AR in the same
    // cycle.
    always_comb begin
        ar_hit     = 1'b0;
        ar_idx     = '0;
        r_hit      = 1'b0;
        r_idx      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < MaxUniqIds; i++) begin
            if (ent_valid[i] && (ent_id[i] == ar_id_i) && !ar_hit) begin
                ar_hit = 1'b1;
                ar_idx = IdxW'(i);
            end
            if (ent_valid[i] && (ent_id[i] == r_id_i) && !r_hit) begin
                r_hit = 1'b1;
                r_idx = IdxW'(i);
            end
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // An AR has no slot in two cases: its ID is tracked but the count is
    // saturated, or its ID is untracked and every entry is taken.
    assign no_slot   = ar_hit ? (ent_cnt[ar_idx] == TxnW'(MaxRdTxns)) : ~free_found;
    assign ar_accept = ar_hs & ~no_slot;

    // Per-entry decode of this cycle's table operations and budget expiry.
    always_comb begin
        ar_sel    = '0;
        alloc_sel = '0;
        done_sel  = '0;
        expired   = '0;
        for (int i = 0; i < MaxUniqIds; i++) begin
            ar_sel[i]    = ar_accept & ar_hit & (ar_idx == IdxW'(i));
            alloc_sel[i] = ar_accept & ~ar_hit & (free_idx == IdxW'(i));
            done_sel[i]  = r_hs & r_hit & (r_idx == IdxW'(i));
            expired[i]   = ent_valid[i] & (ent_budget[i] == '0);
        end
    end

    assign timeout   = tick & (|expired);
    assign fault_now = idle & (timeout | (r_hs & ~r_hit));

    // Table update.  On a tick, the budget of each valid entry counts down.
    // A handshake that touches the same entry then overrides that default.
    // An AR hit combined with an R-last on the same entry leaves the count
    // unchanged and reloads the budget, so that entry can never be freed in
    // that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid <= '0;
            for (int i = 0; i < MaxUniqIds; i++) begin
                ent_id[i]     <= '0;
                ent_cnt[i]    <= '0;
                ent_budget[i] <= '0;
            end
        end else if (state == CLEAR) begin
            ent_valid <= '0;
            for (int i = 0; i < MaxUniqIds; i++) begin
                ent_cnt[i] <= '0;
            end
        end else if (idle) begin
            for (int i = 0; i < MaxUniqIds; i++) begin
                if (ent_valid[i] && tick && (ent_budget[i] != '0)) begin
                    ent_budget[i] <= ent_budget[i] - CntWidth'(1);
                end
                if (alloc_sel[i]) begin
                    ent_valid[i]  <= 1'b1;
                    ent_id[i]     <= ar_id_i;
                    ent_cnt[i]    <= TxnW'(1);
                    ent_budget[i] <= budget_i;
                end else if (ar_sel[i] && done_sel[i]) begin
                    ent_budget[i] <= budget_i;
                end else if (ar_sel[i]) begin
                    ent_cnt[i] <= ent_cnt[i] + TxnW'(1);
                end else if (done_sel[i]) begin
                    if (ent_cnt[i] == TxnW'(1)) begin
                        ent_valid[i] <= 1'b0;
                        ent_cnt[i]   <= '0;
                    end else begin
                        ent_cnt[i]    <= ent_cnt[i] - TxnW'(1);
                        ent_budget[i] <= budget_i;
                    end
                end
            end
        end
    end

    // Control FSM, prescaler and sticky errors.  A fault is first captured
    // in 'fault', and the FSM moves on the following edge.  An event sampled
    // at edge N therefore raises reset_req_o and irq_o after edge N+1.
    // While the reset request is held, everything is frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            presc    <= '0;
            fault    <= 1'b0;
            irq      <= 1'b0;
            err_spur <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fault <= fault_now;
                    irq   <= fault;
                    if (fault) begin
                        state <= RESET_REQ;
                    end
                    if (tick) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PreW'(1);
                    end
                    if (r_hs && !r_hit) begin
                        err_spur <= 1'b1;
                    end
                    if (ar_hs && no_slot) begin
                        err_ovf <= 1'b1;
                    end
                end
                RESET_REQ: begin
                    fault <= 1'b0;
                    irq   <= 1'b0;
                    if (reset_clear_i) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state    <= IDLE;
                    presc    <= '0;
                    fault    <= 1'b0;
                    irq      <= 1'b0;
                    err_spur <= 1'b0;
                    err_ovf  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    fault <= 1'b0;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    assign ar_block_o  = ~idle | no_slot;
    assign reset_req_o = (state == RESET_REQ);
    assign irq_o       = irq;
    assign err_spur_o  = err_spur;
    assign err_ovf_o   = err_ovf;

endmodule
